seq_detector_param: RTL and testbench

Parametrised serial pattern detector built on a shift register. It is the successor to the fixed 6-bit shift-register sequence detector. Pattern length is set by parameter. The pattern is loadable at run time, bits are qualified by a valid strobe, and overlapping or non-overlapping detection is selectable. A saturating match counter is included. It sits between a serial bit source and control/debug logic, which read the pulse, the count and the live shift register.

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Parametrised serial pattern detector with run-time loadable
//            pattern, valid-qualified input, selectable overlap and a
//            saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 WIDTH           = 6,
    parameter int                 CNT_W           = 8,
    parameter logic [WIDTH-1:0]   DEFAULT_PATTERN = 6'b101011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pattern_load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             clear_count,
    output logic             out,
    output logic [WIDTH-1:0] register,
    output logic [CNT_W-1:0] match_count,
    output logic             fill_done
);

    localparam int               FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] C_FULL    = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_pattern;
    logic [FILL_W-1:0] r_fill;
    logic              r_out;
    logic              r_fill_done;
    logic [CNT_W-1:0]  r_count;

    logic [WIDTH-1:0]  w_shifted;
    logic [FILL_W-1:0] w_fill_inc;
    logic [FILL_W-1:0] w_fill_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_match;

    assign w_shifted  = {r_shift[WIDTH-2:0], in};
    assign w_fill_inc = (r_fill == C_FULL) ? C_FULL : r_fill + FILL_W'(1);

    // A pattern load restarts the window, so no match is judged on that edge.
    assign w_match = in_valid && !pattern_load && (w_fill_inc == C_FULL)
                     && (w_shifted == r_pattern);

    always_comb begin
        w_fill_next = r_fill;
        if (pattern_load) begin
            w_fill_next = in_valid ? FILL_W'(1) : '0;
        end else if (in_valid) begin
            w_fill_next = (w_match && !overlap) ? '0 : w_fill_inc;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (clear_count) begin
            w_count_next = w_match ? CNT_W'(1) : '0;
        end else if (w_match && (r_count != C_CNT_MAX)) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_pattern   <= DEFAULT_PATTERN;
            r_fill      <= '0;
            r_out       <= 1'b0;
            r_fill_done <= 1'b0;
            r_count     <= '0;
        end else begin
            if (in_valid) begin
                r_shift <= w_shifted;
            end
            if (pattern_load) begin
                r_pattern <= pattern_in;
            end
            r_fill      <= w_fill_next;
            r_fill_done <= (w_fill_next == C_FULL);
            r_out       <= w_match;
            r_count     <= w_count_next;
        end
    end

    assign out         = r_out;
    assign register    = r_shift;
    assign match_count = r_count;
    assign fill_done   = r_fill_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Scoreboard bench for seq_detector_param (4-bit and 6-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    typedef struct {
        logic       o;
        logic [7:0] c;
        logic [5:0] r;
        logic       fd;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit build: all-zero default pattern, 2-bit counter
    logic       rst4, in4, v4, ov4, ld4, clr4;
    logic [3:0] pin4;
    logic       out4, fd4;
    logic [3:0] reg4;
    logic [1:0] cnt4;

    // 6-bit build with default parameters
    logic       rst6, in6, v6, ov6, ld6, clr6;
    logic [5:0] pin6;
    logic       out6, fd6;
    logic [5:0] reg6;
    logic [7:0] cnt6;

    seq_detector_param #(.WIDTH(4), .CNT_W(2), .DEFAULT_PATTERN(4'b0000)) dut4 (
        .clk(clk), .reset(rst4), .in(in4), .in_valid(v4), .overlap(ov4),
        .pattern_load(ld4), .pattern_in(pin4), .clear_count(clr4),
        .out(out4), .register(reg4), .match_count(cnt4), .fill_done(fd4)
    );

    seq_detector_param dut6 (
        .clk(clk), .reset(rst6), .in(in6), .in_valid(v6), .overlap(ov6),
        .pattern_load(ld6), .pattern_in(pin6), .clear_count(clr6),
        .out(out6), .register(reg6), .match_count(cnt6), .fill_done(fd6)
    );

    exp_t q4[$];
    exp_t q6[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   step4   = 0;
    int   step6   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Monitor: one expected record per driven edge, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk($sformatf("d4#%0d out", e.id),       {7'b0, out4}, {7'b0, e.o});
            chk($sformatf("d4#%0d count", e.id),     {6'b0, cnt4}, e.c);
            chk($sformatf("d4#%0d register", e.id),  {4'b0, reg4}, {2'b0, e.r});
            chk($sformatf("d4#%0d fill_done", e.id), {7'b0, fd4},  {7'b0, e.fd});
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            chk($sformatf("d6#%0d out", e.id),       {7'b0, out6}, {7'b0, e.o});
            chk($sformatf("d6#%0d count", e.id),     cnt6,         e.c);
            chk($sformatf("d6#%0d register", e.id),  {2'b0, reg6}, {2'b0, e.r});
            chk($sformatf("d6#%0d fill_done", e.id), {7'b0, fd6},  {7'b0, e.fd});
        end
    end

    task automatic s4(input logic i, input logic v, input logic eo,
                      input logic [1:0] ec, input logic [3:0] er, input logic efd);
        exp_t e;
        in4 = i;
        v4  = v;
        @(posedge clk);
        e.o = eo; e.c = {6'b0, ec}; e.r = {2'b0, er}; e.fd = efd; e.id = step4++;
        q4.push_back(e);
        #1;
        ld4 = 1'b0; clr4 = 1'b0; v4 = 1'b0;
    endtask

    task automatic s6(input logic i, input logic v, input logic eo,
                      input logic [7:0] ec, input logic [5:0] er, input logic efd);
        exp_t e;
        in6 = i;
        v6  = v;
        @(posedge clk);
        e.o = eo; e.c = ec; e.r = er; e.fd = efd; e.id = step6++;
        q6.push_back(e);
        #1;
        ld6 = 1'b0; clr6 = 1'b0; v6 = 1'b0;
    endtask

    logic [1:0] sat_before [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] sat_after  [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst4 = 1'b1; in4 = 1'b0; v4 = 1'b0; ov4 = 1'b1; ld4 = 1'b0; clr4 = 1'b0; pin4 = '0;
        rst6 = 1'b1; in6 = 1'b0; v6 = 1'b0; ov6 = 1'b1; ld6 = 1'b0; clr6 = 1'b0; pin6 = '0;
        #12;
        chk("rst4 out", {7'b0, out4}, 8'd0);
        chk("rst4 register", {4'b0, reg4}, 8'd0);
        chk("rst4 count", {6'b0, cnt4}, 8'd0);
        chk("rst4 fill_done", {7'b0, fd4}, 8'd0);
        rst4 = 1'b0;
        rst6 = 1'b0;

        // Fill guard: zero pattern must wait for four valid bits
        s4(0, 1, 0, 2'd0, 4'b0000, 0);
        s4(0, 1, 0, 2'd0, 4'b0000, 0);
        s4(0, 1, 0, 2'd0, 4'b0000, 0);
        s4(0, 1, 1, 2'd1, 4'b0000, 1);
        s4(0, 0, 0, 2'd1, 4'b0000, 1);

        // Overlapping detection of 1010
        ld4 = 1'b1; pin4 = 4'b1010; clr4 = 1'b1;
        s4(0, 0, 0, 2'd0, 4'b0000, 0);
        s4(1, 1, 0, 2'd0, 4'b0001, 0);
        s4(0, 1, 0, 2'd0, 4'b0010, 0);
        s4(1, 1, 0, 2'd0, 4'b0101, 0);
        s4(0, 1, 1, 2'd1, 4'b1010, 1);
        s4(1, 1, 0, 2'd1, 4'b0101, 1);
        s4(0, 1, 1, 2'd2, 4'b1010, 1);

        // Non-overlapping detection of 1010
        ov4 = 1'b0; ld4 = 1'b1; pin4 = 4'b1010; clr4 = 1'b1;
        s4(0, 0, 0, 2'd0, 4'b1010, 0);
        s4(1, 1, 0, 2'd0, 4'b0101, 0);
        s4(0, 1, 0, 2'd0, 4'b1010, 0);
        s4(1, 1, 0, 2'd0, 4'b0101, 0);
        s4(0, 1, 1, 2'd1, 4'b1010, 0);
        s4(1, 1, 0, 2'd1, 4'b0101, 0);
        s4(0, 1, 0, 2'd1, 4'b1010, 0);

        // Load with simultaneous valid bit, then clear coinciding with a match
        ov4 = 1'b1; ld4 = 1'b1; pin4 = 4'b1100;
        s4(1, 1, 0, 2'd1, 4'b0101, 0);
        s4(1, 1, 0, 2'd1, 4'b1011, 0);
        s4(0, 1, 0, 2'd1, 4'b0110, 0);
        clr4 = 1'b1;
        s4(0, 1, 1, 2'd1, 4'b1100, 1);

        // Counter saturation at 3
        for (int k = 0; k < 4; k++) begin
            s4(1, 1, 0, sat_before[k], 4'b1001, 1);
            s4(1, 1, 0, sat_before[k], 4'b0011, 1);
            s4(0, 1, 0, sat_before[k], 4'b0110, 1);
            s4(0, 1, 1, sat_after[k],  4'b1100, 1);
        end
        clr4 = 1'b1;
        s4(0, 0, 0, 2'd0, 4'b1100, 1);

        // Default pattern with a two-cycle valid gap
        s6(1, 1, 0, 8'd0, 6'b000001, 0);
        s6(0, 1, 0, 8'd0, 6'b000010, 0);
        s6(1, 1, 0, 8'd0, 6'b000101, 0);
        s6(0, 0, 0, 8'd0, 6'b000101, 0);
        s6(0, 0, 0, 8'd0, 6'b000101, 0);
        s6(0, 1, 0, 8'd0, 6'b001010, 0);
        s6(1, 1, 0, 8'd0, 6'b010101, 0);
        s6(1, 1, 1, 8'd1, 6'b101011, 1);
        s6(0, 0, 0, 8'd1, 6'b101011, 1);

        // Replace pattern, run partway, then async reset must restore default
        ld6 = 1'b1; pin6 = 6'b111111;
        s6(0, 0, 0, 8'd1, 6'b101011, 0);
        s6(1, 1, 0, 8'd1, 6'b010111, 0);
        s6(0, 1, 0, 8'd1, 6'b101110, 0);
        s6(1, 1, 0, 8'd1, 6'b011101, 0);
        @(negedge clk);
        #1 rst6 = 1'b1;
        #1;
        chk("arst6 out", {7'b0, out6}, 8'd0);
        chk("arst6 register", {2'b0, reg6}, 8'd0);
        chk("arst6 count", cnt6, 8'd0);
        chk("arst6 fill_done", {7'b0, fd6}, 8'd0);
        @(posedge clk);
        #2 rst6 = 1'b0;
        s6(1, 1, 0, 8'd0, 6'b000001, 0);
        s6(0, 1, 0, 8'd0, 6'b000010, 0);
        s6(1, 1, 0, 8'd0, 6'b000101, 0);
        s6(0, 1, 0, 8'd0, 6'b001010, 0);
        s6(1, 1, 0, 8'd0, 6'b010101, 0);
        s6(1, 1, 1, 8'd1, 6'b101011, 1);
        s6(0, 0, 0, 8'd1, 6'b101011, 1);

        for (int k = 0; k < 20 && (q4.size() > 0 || q6.size() > 0); k++) @(negedge clk);
        if (q4.size() > 0 || q6.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q4.size() + q6.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
